vram_console: RTL and testbench

VRAM_CONSOLE -- requirements
Module: vram_console

---
 rtl/vram_console.sv | 147 ++++++++++++++
 tb/tb_vram_console.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_console.sv
// Text console writer for a COLS x ROWS character VRAM.
// Consumes a character stream (printables plus BS/LF/FF/CR), drives the VRAM
// write port and tracks the cursor. Reset and form-feed blank the whole screen.
module vram_console #(
  parameter int          COLS  = 60,
  parameter int          ROWS  = 17,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       v_cea,
  output logic [9:0] v_ada,
  output logic [7:0] v_din,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam logic [9:0] COLS_W    = 10'(COLS);
  localparam logic [9:0] LAST_ADDR = 10'(COLS * ROWS - 1);
  localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE
  } state_t;

  state_t     state;
  logic [9:0] clr_cnt;
  logic [9:0] cur_addr;
  logic [4:0] next_row;
  logic       accept;

  // Linear VRAM address of the cursor cell; never exceeds COLS*ROWS-1.
  assign cur_addr = ({5'd0, cursor_row} * COLS_W) + {4'd0, cursor_col};
  // Row advance wraps to the top; the console never scrolls.
  assign next_row = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
  // char_ready is only ever high in IDLE, so this is the full handshake.
  assign accept   = char_valid & char_ready;

  // Control FSM with all outputs registered; reset parks in CLEAR so the
  // screen is blanked on the first cycle after release.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see new values.
    if (rst) begin
      state      <= ST_CLEAR;
      clr_cnt    <= 10'd0;
      char_ready <= 1'b0;
      v_cea      <= 1'b0;
      v_ada      <= 10'd0;
      v_din      <= 8'd0;
      cursor_col <= 6'd0;
      cursor_row <= 5'd0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          v_cea      <= 1'b1;
          v_ada      <= clr_cnt;
          v_din      <= BLANK;
          busy       <= 1'b1;
          char_ready <= 1'b0;
          if (clr_cnt == LAST_ADDR) begin
            clr_cnt <= 10'd0;
            state   <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 10'd1;
          end
        end

        ST_WRITE: begin
          v_cea      <= 1'b0;
          busy       <= 1'b0;
          char_ready <= 1'b1;
          state      <= ST_IDLE;
        end

        ST_IDLE: begin
          v_cea      <= 1'b0;
          busy       <= 1'b0;
          char_ready <= 1'b1;
          if (accept) begin
            case (char_data)
              CH_CR: begin
                cursor_col <= 6'd0;
              end
              CH_LF: begin
                cursor_col <= 6'd0;
                cursor_row <= next_row;
              end
              CH_FF: begin
                cursor_col <= 6'd0;
                cursor_row <= 5'd0;
                clr_cnt    <= 10'd0;
                char_ready <= 1'b0;
                state      <= ST_CLEAR;
              end
              CH_BS: begin
                // Backspace at column 0 is ignored and the block stays ready.
                if (cursor_col != 6'd0) begin
                  cursor_col <= cursor_col - 6'd1;
                  v_cea      <= 1'b1;
                  v_ada      <= cur_addr - 10'd1;
                  v_din      <= BLANK;
                  char_ready <= 1'b0;
                  state      <= ST_WRITE;
                end
              end
              default: begin
                v_cea      <= 1'b1;
                v_ada      <= cur_addr;
                v_din      <= char_data;
                char_ready <= 1'b0;
                state      <= ST_WRITE;
                if (cursor_col == LAST_COL) begin
                  cursor_col <= 6'd0;
                  cursor_row <= next_row;
                end else begin
                  cursor_col <= cursor_col + 6'd1;
                end
              end
            endcase
          end
        end

        default: begin
          v_cea      <= 1'b0;
          char_ready <= 1'b0;
          clr_cnt    <= 10'd0;
          state      <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_console.sv
// Directed testbench for vram_console: reset clear, printing, wrap, CR/LF,
// backspace and reset during a form-feed clear.
module tb_vram_console;

  logic       clk;
  logic       rst;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       v_cea;
  logic [9:0] v_ada;
  logic [7:0] v_din;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  int checks = 0;
  int errors = 0;

  vram_console dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .v_cea      (v_cea),
    .v_ada      (v_ada),
    .v_din      (v_din),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one character from a negedge, wait for the handshake, and return
  // at the negedge just after the accepting edge.
  task automatic send(input logic [7:0] c);
    int n = 0;
    char_valid = 1'b1;
    char_data  = c;
    while (char_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (char_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout char=%h ready=%b required 1", c, char_ready);
    end
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  // Count clear pulses until v_cea drops; expect 1020 sequential blank writes.
  task automatic run_clear(input string tag);
    int pulses = 0;
    int bad    = 0;
    int nobusy = 0;
    int n      = 0;
    while (n < 1200 && !(pulses > 0 && v_cea === 1'b0)) begin
      @(negedge clk);
      n++;
      if (v_cea === 1'b1) begin
        if (v_ada !== 10'(pulses) || v_din !== 8'h20) bad++;
        if (busy !== 1'b1) nobusy++;
        pulses++;
      end
    end
    checks++;
    if (pulses != 1020) begin
      errors++;
      $display("FAIL %s_pulses got %0d required 1020", tag, pulses);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_addr_data bad_writes %0d required 0", tag, bad);
    end
    checks++;
    if (nobusy != 0) begin
      errors++;
      $display("FAIL %s_busy_during not_busy_writes %0d required 0", tag, nobusy);
    end
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_after got %b required 1", tag, char_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_after got %b required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (v_cea !== 1'b0 || v_ada !== 10'd0 || v_din !== 8'd0) begin
      errors++;
      $display("FAIL reset_vram cea=%b ada=%0d din=%h required 0/0/00", v_cea, v_ada, v_din);
    end
    checks++;
    if (cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL reset_cursor got (%0d,%0d) required (0,0)", cursor_col, cursor_row);
    end
    checks++;
    if (char_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags ready=%b busy=%b required 0/0", char_ready, busy);
    end
    rst = 1'b0;
    run_clear("power_clear");
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int nw   = 0;
    int cyc  = 0;
    int wc[2];
    logic [9:0] wa[2];
    logic [7:0] wd[2];
    bit acc;
    char_valid = 1'b1;
    char_data  = 8'h41;
    for (int i = 0; i < 8; i++) begin
      acc = (char_valid === 1'b1) && (char_ready === 1'b1);
      @(negedge clk);
      cyc++;
      if (acc) begin
        sent++;
        if (sent == 1) char_data = 8'h42;
        else char_valid = 1'b0;
      end
      if (v_cea === 1'b1 && nw < 2) begin
        wc[nw] = cyc;
        wa[nw] = v_ada;
        wd[nw] = v_din;
        nw++;
      end
    end
    checks++;
    if (nw != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d writes required 2", nw);
    end else begin
      checks++;
      if (wa[0] !== 10'd0 || wd[0] !== 8'h41) begin
        errors++;
        $display("FAIL b2b_first got ada=%0d din=%h required 0/41", wa[0], wd[0]);
      end
      checks++;
      if (wa[1] !== 10'd1 || wd[1] !== 8'h42) begin
        errors++;
        $display("FAIL b2b_second got ada=%0d din=%h required 1/42", wa[1], wd[1]);
      end
      checks++;
      if (wc[1] - wc[0] != 2) begin
        errors++;
        $display("FAIL b2b_spacing got %0d cycles required 2", wc[1] - wc[0]);
      end
    end
    checks++;
    if (cursor_col !== 6'd2 || cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL b2b_cursor got (%0d,%0d) required (2,0)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_wrap();
    // From (2,0): 16 LFs -> (0,16), then 59 printables -> (59,16).
    for (int i = 0; i < 16; i++) send(8'h0A);
    for (int i = 0; i < 59; i++) send(8'h78);
    checks++;
    if (cursor_col !== 6'd59 || cursor_row !== 5'd16) begin
      errors++;
      $display("FAIL wrap_setup got (%0d,%0d) required (59,16)", cursor_col, cursor_row);
    end
    send(8'h5A);
    checks++;
    if (v_cea !== 1'b1 || v_ada !== 10'd1019 || v_din !== 8'h5A) begin
      errors++;
      $display("FAIL wrap_write cea=%b ada=%0d din=%h required 1/1019/5a", v_cea, v_ada, v_din);
    end
    checks++;
    if (cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL wrap_cursor got (%0d,%0d) required (0,0)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_cr_lf();
    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61);
    send(8'h0D);
    checks++;
    if (v_cea !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd3) begin
      errors++;
      $display("FAIL cr cea=%b cursor (%0d,%0d) required 0 (0,3)", v_cea, cursor_col, cursor_row);
    end
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL cr_ready got %b required 1", char_ready);
    end
    for (int i = 0; i < 13; i++) send(8'h0A);
    checks++;
    if (cursor_row !== 5'd16) begin
      errors++;
      $display("FAIL lf_setup row got %0d required 16", cursor_row);
    end
    send(8'h0A);
    checks++;
    if (v_cea !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL lf_wrap cea=%b cursor (%0d,%0d) required 0 (0,0)", v_cea, cursor_col, cursor_row);
    end
  endtask

  task automatic test_backspace();
    for (int i = 0; i < 2; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h62);
    send(8'h08);
    checks++;
    if (v_cea !== 1'b1 || v_ada !== 10'd124 || v_din !== 8'h20) begin
      errors++;
      $display("FAIL bs_write cea=%b ada=%0d din=%h required 1/124/20", v_cea, v_ada, v_din);
    end
    checks++;
    if (cursor_col !== 6'd4 || cursor_row !== 5'd2) begin
      errors++;
      $display("FAIL bs_cursor got (%0d,%0d) required (4,2)", cursor_col, cursor_row);
    end
    send(8'h0D);
    send(8'h08);
    checks++;
    if (v_cea !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd2) begin
      errors++;
      $display("FAIL bs_col0 cea=%b cursor (%0d,%0d) required 0 (0,2)", v_cea, cursor_col, cursor_row);
    end
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL bs_col0_ready got %b required 1", char_ready);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    send(8'h0C);
    checks++;
    if (cursor_col !== 6'd0 || cursor_row !== 5'd0 || char_ready !== 1'b0) begin
      errors++;
      $display("FAIL ff_enter cursor (%0d,%0d) ready=%b required (0,0) 0", cursor_col, cursor_row, char_ready);
    end
    while (n < 1200 && !(v_cea === 1'b1 && v_ada === 10'd500)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (v_cea !== 1'b1 || v_ada !== 10'd500) begin
      errors++;
      $display("FAIL ff_reach_500 cea=%b ada=%0d required 1/500", v_cea, v_ada);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (v_cea !== 1'b0 || v_ada !== 10'd0 || v_din !== 8'd0 || busy !== 1'b0
        || char_ready !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL abort_reset cea=%b ada=%0d din=%h busy=%b ready=%b required all 0",
               v_cea, v_ada, v_din, busy, char_ready);
    end
    rst = 1'b0;
    run_clear("restart_clear");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_cr_lf();
    test_backspace();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
